// File: rtl/eer_pkt_pkg.sv
// Shared definitions for the EER-RL packet filter / dispatcher.
// Contents:
//   *_DEF          default field widths used by the header struct and the top
//   PKT_*          packet type codes (5..7 are reserved)
//   BROADCAST_ID   all-ones destination; sliced down to the node ID width
//   hdr_t          header record at the default widths
//   state_t        dispatcher FSM states
package eer_pkt_pkg;

  localparam int WORD_WIDTH_DEF = 16;
  localparam int PKT_TYPE_W_DEF = 3;
  localparam int SEQ_W_DEF      = 8;

  localparam int unsigned PKT_HELLO       = 0;
  localparam int unsigned PKT_CH_ANNOUNCE = 1;
  localparam int unsigned PKT_JOIN        = 2;
  localparam int unsigned PKT_DATA        = 3;
  localparam int unsigned PKT_FEEDBACK    = 4;

  // Wide enough for any sensible node ID width; users take the low bits.
  localparam logic [63:0] BROADCAST_ID = '1;

  typedef struct packed {
    logic [PKT_TYPE_W_DEF-1:0] ptype;
    logic [WORD_WIDTH_DEF-1:0] src;
    logic [WORD_WIDTH_DEF-1:0] dst;
    logic [SEQ_W_DEF-1:0]      seq;
  } hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_ISSUE,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/pkt_hdr_fifo.sv
// Synchronous FIFO of packet headers.
// Ports:
//   clk, nrst      clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data  write strobe and header; ignored while full
//   pop, rd_data   read strobe; rd_data shows the head entry while !empty
//   full, empty    status flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module pkt_hdr_fifo
  import eer_pkt_pkg::*;
#(
  parameter type T     = hdr_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic push,
  input  T     wr_data,
  input  logic pop,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        push_ok;
  logic        pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage carries no reset; stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/pkt_filter_dispatch.sv
// Packet filter and dispatcher for one routing node.
// Headers are buffered in a FIFO, then filtered (reserved type, address,
// duplicate/echo) and each survivor is handed to exactly one unit through a
// one-cycle enable, followed by a wait for unitDone bounded by TIMEOUT.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   newpkt, fPktType, fSourceID, fDestinationID, fPktSeq   header input
//   myNodeID                  local node ID (quasi-static)
//   unitDone                  completion strobe from the enabled unit
//   pktReady                  FIFO not full
//   en_QTU/KCH/MNI/reward/fwd, iAmDestination   one-cycle dispatch enables
//   curSourceID               source of the packet in ISSUE/WAIT
//   dropCount                 saturating count of filtered packets
//   overflow, timeoutErr      sticky error flags
module pkt_filter_dispatch
  import eer_pkt_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int PKT_TYPE_W = PKT_TYPE_W_DEF,
  parameter int SEQ_W      = SEQ_W_DEF,
  parameter int QDEPTH     = 4,
  parameter int DUP_DEPTH  = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  newpkt,
  input  logic [PKT_TYPE_W-1:0] fPktType,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fDestinationID,
  input  logic [SEQ_W-1:0]      fPktSeq,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  unitDone,
  output logic                  pktReady,
  output logic                  en_QTU,
  output logic                  en_KCH,
  output logic                  en_MNI,
  output logic                  en_reward,
  output logic                  en_fwd,
  output logic                  iAmDestination,
  output logic [WORD_WIDTH-1:0] curSourceID,
  output logic [CNT_W-1:0]      dropCount,
  output logic                  overflow,
  output logic                  timeoutErr
);

  localparam int DUP_PTR_W = (DUP_DEPTH > 1) ? $clog2(DUP_DEPTH) : 1;
  localparam int TO_W      = $clog2(TIMEOUT) + 1;

  typedef struct packed {
    logic [PKT_TYPE_W-1:0] ptype;
    logic [WORD_WIDTH-1:0] src;
    logic [WORD_WIDTH-1:0] dst;
    logic [SEQ_W-1:0]      seq;
  } hdr_loc_t;

  hdr_loc_t fifo_wr_data;
  hdr_loc_t fifo_rd_data;
  hdr_loc_t hdr_reg;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;

  state_t state_reg;
  state_t state_next;

  logic [WORD_WIDTH-1:0] dup_src_reg [DUP_DEPTH];
  logic [SEQ_W-1:0]      dup_seq_reg [DUP_DEPTH];
  logic [DUP_DEPTH-1:0]  dup_valid_reg;
  logic [DUP_DEPTH-1:0]  dup_match;
  logic [DUP_PTR_W-1:0]  dup_ptr_reg;

  logic [TO_W-1:0]       to_cnt_reg;
  logic [CNT_W-1:0]      drop_cnt_reg;
  logic                  overflow_reg;
  logic                  timeout_reg;
  logic [WORD_WIDTH-1:0] cur_src_reg;

  logic is_hello, is_announce, is_join, is_data, is_feedback;
  logic dst_is_me, dst_is_bcast, type_ok, addr_ok, is_echo, drop;
  logic to_hit;
  logic accept;

  // ---------------------------------------------------------------- FIFO
  assign fifo_wr_data = '{ptype: fPktType, src: fSourceID,
                          dst: fDestinationID, seq: fPktSeq};
  // Only the current full flag gates a push; a same-cycle pop does not help.
  assign fifo_push = newpkt && !fifo_full;
  assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;

  pkt_hdr_fifo #(
    .T     (hdr_loc_t),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (fifo_push),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ------------------------------------------------------- filter rules
  for (genvar gi = 0; gi < DUP_DEPTH; gi++) begin : g_dup
    assign dup_match[gi] = dup_valid_reg[gi] &&
                           (dup_src_reg[gi] == hdr_reg.src) &&
                           (dup_seq_reg[gi] == hdr_reg.seq);
  end

  always_comb begin
    is_hello     = (hdr_reg.ptype == PKT_TYPE_W'(PKT_HELLO));
    is_announce  = (hdr_reg.ptype == PKT_TYPE_W'(PKT_CH_ANNOUNCE));
    is_join      = (hdr_reg.ptype == PKT_TYPE_W'(PKT_JOIN));
    is_data      = (hdr_reg.ptype == PKT_TYPE_W'(PKT_DATA));
    is_feedback  = (hdr_reg.ptype == PKT_TYPE_W'(PKT_FEEDBACK));
    dst_is_me    = (hdr_reg.dst == myNodeID);
    dst_is_bcast = (hdr_reg.dst == BROADCAST_ID[WORD_WIDTH-1:0]);
    type_ok      = is_hello || is_announce || is_join || is_data || is_feedback;
    // Only JOIN and FEEDBACK are address-filtered.
    addr_ok      = !(is_join || is_feedback) || dst_is_me || dst_is_bcast;
    is_echo      = (hdr_reg.src == myNodeID);
    drop         = !type_ok || !addr_ok || (|dup_match) || is_echo;
  end

  assign to_hit = (to_cnt_reg == TO_W'(TIMEOUT - 1));
  assign accept = (state_reg == ST_LOOKUP) && !drop;

  // ------------------------------------------------------ state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= ST_IDLE;
      hdr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (fifo_pop) hdr_reg <= fifo_rd_data;
    end
  end

  // ---------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (!fifo_empty) state_next = ST_LOOKUP;
      ST_LOOKUP: state_next = drop ? ST_IDLE : ST_ISSUE;
      ST_ISSUE:  state_next = unitDone ? ST_IDLE : ST_WAIT;
      ST_WAIT:   if (unitDone || to_hit) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ outputs
  always_comb begin
    en_QTU         = 1'b0;
    en_KCH         = 1'b0;
    en_MNI         = 1'b0;
    en_reward      = 1'b0;
    en_fwd         = 1'b0;
    iAmDestination = 1'b0;
    if (state_reg == ST_ISSUE) begin
      en_QTU         = is_hello;
      en_KCH         = is_announce;
      en_MNI         = is_join;
      en_reward      = is_feedback;
      iAmDestination = is_data && dst_is_me;
      en_fwd         = is_data && !dst_is_me;
    end
  end

  // ------------------------------------ counters, cache and sticky flags
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DUP_DEPTH; i++) begin
        dup_src_reg[i] <= '0;
        dup_seq_reg[i] <= '0;
      end
      dup_valid_reg <= '0;
      dup_ptr_reg   <= '0;
      to_cnt_reg    <= '0;
      drop_cnt_reg  <= '0;
      overflow_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      cur_src_reg   <= '0;
    end else begin
      if (newpkt && fifo_full) overflow_reg <= 1'b1;

      if ((state_reg == ST_LOOKUP) && drop && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end

      // Accepted packets overwrite the oldest cache slot (round robin).
      if (accept) begin
        for (int i = 0; i < DUP_DEPTH; i++) begin
          if (dup_ptr_reg == DUP_PTR_W'(i)) begin
            dup_src_reg[i]   <= hdr_reg.src;
            dup_seq_reg[i]   <= hdr_reg.seq;
            dup_valid_reg[i] <= 1'b1;
          end
        end
        dup_ptr_reg <= (dup_ptr_reg == DUP_PTR_W'(DUP_DEPTH - 1)) ?
                       '0 : dup_ptr_reg + DUP_PTR_W'(1);
        cur_src_reg <= hdr_reg.src;
      end

      if (state_reg == ST_ISSUE) begin
        to_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT) begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
        if (!unitDone && to_hit) timeout_reg <= 1'b1;
      end
    end
  end

  assign pktReady    = !fifo_full;
  assign curSourceID = cur_src_reg;
  assign dropCount   = drop_cnt_reg;
  assign overflow    = overflow_reg;
  assign timeoutErr  = timeout_reg;

endmodule

// File: tb/tb_pkt_filter_dispatch.sv
module tb_pkt_filter_dispatch;

  localparam int DD = 4;
  localparam int TO = 64;
  localparam logic [15:0] MY = 16'd9;

  localparam int U_QTU = 0, U_KCH = 1, U_MNI = 2, U_SINK = 3, U_FWD = 4,
                 U_REW = 5, U_DROP = 7;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        newpkt = 1'b0;
  logic [2:0]  fPktType = '0;
  logic [15:0] fSourceID = '0;
  logic [15:0] fDestinationID = '0;
  logic [7:0]  fPktSeq = '0;
  logic [15:0] myNodeID = MY;
  logic        unitDone = 1'b0;
  logic        pktReady, en_QTU, en_KCH, en_MNI, en_reward, en_fwd;
  logic        iAmDestination, overflow, timeoutErr;
  logic [15:0] curSourceID;
  logic [7:0]  dropCount;

  pkt_filter_dispatch #(
    .WORD_WIDTH(16), .PKT_TYPE_W(3), .SEQ_W(8), .QDEPTH(4),
    .DUP_DEPTH(DD), .TIMEOUT(TO), .CNT_W(8)
  ) dut (
    .clk(clk), .nrst(nrst), .newpkt(newpkt), .fPktType(fPktType),
    .fSourceID(fSourceID), .fDestinationID(fDestinationID),
    .fPktSeq(fPktSeq), .myNodeID(myNodeID), .unitDone(unitDone),
    .pktReady(pktReady), .en_QTU(en_QTU), .en_KCH(en_KCH),
    .en_MNI(en_MNI), .en_reward(en_reward), .en_fwd(en_fwd),
    .iAmDestination(iAmDestination), .curSourceID(curSourceID),
    .dropCount(dropCount), .overflow(overflow), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          unit;
    logic [15:0] src;
    int          cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  // Reference model state: the last DD accepted (src,seq) keys, oldest first.
  logic [23:0] cache_q[$];
  int          exp_drops = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Dispatch monitor: records every enable pulse and checks exclusivity.
  always @(negedge clk) begin
    int n;
    int u;
    n = 0;
    u = -1;
    if (en_QTU)         begin n++; u = U_QTU;  end
    if (en_KCH)         begin n++; u = U_KCH;  end
    if (en_MNI)         begin n++; u = U_MNI;  end
    if (iAmDestination) begin n++; u = U_SINK; end
    if (en_fwd)         begin n++; u = U_FWD;  end
    if (en_reward)      begin n++; u = U_REW;  end
    if (n > 0) begin
      checks++;
      if (n != 1) begin
        failures++;
        $display("FAIL onehot: got %0d enables required 1 (cycle %0d)", n, cyc);
      end
      obs_q.push_back('{u, curSourceID, cyc});
    end
  end

  function automatic int rule_unit(input logic [2:0] t, input logic [15:0] d);
    case (t)
      3'd0: return U_QTU;
      3'd1: return U_KCH;
      3'd2: return (d == MY || d == 16'hFFFF) ? U_MNI : U_DROP;
      3'd3: return (d == MY) ? U_SINK : U_FWD;
      3'd4: return (d == MY || d == 16'hFFFF) ? U_REW : U_DROP;
      default: return U_DROP;
    endcase
  endfunction

  task automatic model_pkt(input logic [2:0] t, input logic [15:0] s,
                           input logic [15:0] d, input logic [7:0] q);
    int u;
    bit dup;
    u = rule_unit(t, d);
    dup = 1'b0;
    foreach (cache_q[i]) if (cache_q[i] == {s, q}) dup = 1'b1;
    if (u == U_DROP || dup || s == MY) begin
      if (exp_drops < 255) exp_drops++;
    end else begin
      cache_q.push_back({s, q});
      if (cache_q.size() > DD) void'(cache_q.pop_front());
      exp_q.push_back('{u, s, 0});
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [2:0] t, input logic [15:0] s,
                      input logic [15:0] d, input logic [7:0] q,
                      input bit use_model);
    newpkt = 1'b1;
    fPktType = t;
    fSourceID = s;
    fDestinationID = d;
    fPktSeq = q;
    if (use_model) model_pkt(t, s, d, q);
    @(negedge clk);
    newpkt = 1'b0;
  endtask

  task automatic check_dispatches(input string name);
    chk({name, " count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      $display("dispatch %s #%0d unit=%0d src=%0d cyc=%0d", name, i,
               obs_q[i].unit, obs_q[i].src, obs_q[i].cyc);
      chk({name, " unit"}, obs_q[i].unit, exp_q[i].unit);
      chk({name, " src"}, obs_q[i].src, exp_q[i].src);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset(input string name);
    chk({name, " enables"},
        {en_QTU, en_KCH, en_MNI, en_reward, en_fwd, iAmDestination}, 0);
    chk({name, " curSourceID"}, curSourceID, 0);
    chk({name, " dropCount"}, dropCount, 0);
    chk({name, " overflow"}, overflow, 0);
    chk({name, " timeoutErr"}, timeoutErr, 0);
    chk({name, " pktReady"}, pktReady, 1);
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [15:0] s;
    logic [15:0] d;
    logic [7:0]  q;
    int          unit;
  } vec_t;

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int w;

    // ---------------- reset state
    repeat (3) @(negedge clk);
    chk_reset("reset");
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- single HELLO: latency and one-cycle enable
    unitDone = 1'b0;
    t0 = cyc + 1;
    send(3'd0, 16'd5, 16'd0, 8'd1, 1'b1);
    while (cyc < t0 + 4) @(negedge clk);
    unitDone = 1'b1;
    @(negedge clk);
    unitDone = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1 events", obs_q.size(), 1);
    if (obs_q.size() >= 1) chk("t1 latency", obs_q[0].cyc, t0 + 2);
    chk("t1 dropCount", dropCount, 0);
    check_dispatches("t1");

    // ---------------- duplicate then fresh seq; dropped packet costs 2 cycles
    unitDone = 1'b1;
    t0 = cyc + 1;
    send(3'd0, 16'd5, 16'd0, 8'd1, 1'b1);
    send(3'd0, 16'd5, 16'd0, 8'd2, 1'b1);
    repeat (6) @(negedge clk);
    if (obs_q.size() >= 1) chk("t2 latency", obs_q[0].cyc, t0 + 4);
    chk("t2 dropCount", dropCount, exp_drops);
    check_dispatches("t2");

    // ---------------- table-driven rules (myNodeID = 9)
    vt[0]  = '{3'd3, 16'd7, 16'd9,      8'd1, U_SINK};
    vt[1]  = '{3'd3, 16'd7, 16'd3,      8'd2, U_FWD};
    vt[2]  = '{3'd2, 16'd7, 16'd3,      8'd3, U_DROP};
    vt[3]  = '{3'd2, 16'd7, 16'hFFFF,   8'd4, U_MNI};
    vt[4]  = '{3'd6, 16'd7, 16'd9,      8'd5, U_DROP};
    vt[5]  = '{3'd4, 16'd8, 16'd9,      8'd1, U_REW};
    vt[6]  = '{3'd4, 16'd8, 16'd3,      8'd2, U_DROP};
    vt[7]  = '{3'd1, 16'd8, 16'd3,      8'd3, U_KCH};
    vt[8]  = '{3'd0, 16'd9, 16'd0,      8'd1, U_DROP};
    vt[9]  = '{3'd3, 16'd8, 16'd9,      8'd1, U_DROP};
    vt[10] = '{3'd3, 16'd7, 16'd9,      8'd1, U_SINK};
    vt[11] = '{3'd5, 16'd6, 16'd9,      8'd7, U_DROP};
    vt[12] = '{3'd7, 16'd6, 16'hFFFF,   8'd8, U_DROP};
    vt[13] = '{3'd3, 16'd6, 16'hFFFF,   8'd9, U_FWD};
    for (int i = 0; i < 14; i++) begin
      send(vt[i].t, vt[i].s, vt[i].d, vt[i].q, 1'b1);
      repeat (6) @(negedge clk);
      $display("vector %0d type=%0d src=%0d dst=%0h seq=%0d expect=%0d seen=%0d",
               i, vt[i].t, vt[i].s, vt[i].d, vt[i].q, vt[i].unit, obs_q.size());
      if (vt[i].unit == U_DROP) begin
        chk("tbl no dispatch", obs_q.size(), 0);
      end else begin
        chk("tbl dispatch count", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
          chk("tbl unit", obs_q[0].unit, vt[i].unit);
          chk("tbl src", obs_q[0].src, vt[i].s);
        end
      end
      chk("tbl dropCount", dropCount, exp_drops);
      obs_q.delete();
      exp_q.delete();
    end

    // ---------------- randomized traffic against the reference model
    begin
      bit waiting;
      int dly;
      int r;
      waiting = 1'b0;
      dly = 0;
      for (int c = 0; c < 400; c++) begin
        if (en_QTU || en_KCH || en_MNI || en_reward || en_fwd || iAmDestination) begin
          waiting = 1'b1;
          dly = $urandom_range(0, 3);
        end
        if (waiting && dly == 0) begin
          unitDone = 1'b1;
          waiting = 1'b0;
        end else begin
          unitDone = 1'b0;
          if (waiting) dly--;
        end
        if (c < 340 && pktReady && $urandom_range(0, 1) == 1) begin
          newpkt = 1'b1;
          fPktType = 3'($urandom_range(0, 7));
          r = $urandom_range(0, 4);
          fSourceID = (r == 4) ? MY : 16'(r + 1);
          r = $urandom_range(0, 2);
          fDestinationID = (r == 0) ? MY : (r == 1) ? 16'd3 : 16'hFFFF;
          fPktSeq = 8'($urandom_range(0, 3));
          model_pkt(fPktType, fSourceID, fDestinationID, fPktSeq);
        end else begin
          newpkt = 1'b0;
        end
        @(negedge clk);
      end
      newpkt = 1'b0;
      unitDone = 1'b0;
    end
    check_dispatches("rand");
    chk("rand dropCount", dropCount, exp_drops);
    chk("rand overflow", overflow, 0);
    chk("rand timeoutErr", timeoutErr, 0);

    // ---------------- overflow: unit stalled, 5 pushes into 4 slots
    unitDone = 1'b0;
    send(3'd0, 16'd20, 16'd0, 8'd1, 1'b1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) send(3'd0, 16'(21 + k), 16'd0, 8'd1, 1'b1);
    send(3'd0, 16'd25, 16'd0, 8'd1, 1'b0);
    chk("ovf overflow", overflow, 1);
    chk("ovf pktReady full", pktReady, 0);
    repeat (3) @(negedge clk);
    chk("ovf pktReady held", pktReady, 0);
    unitDone = 1'b1;
    @(negedge clk);
    unitDone = 1'b0;
    chk("ovf pktReady before pop", pktReady, 0);
    @(negedge clk);
    chk("ovf pktReady after pop", pktReady, 1);
    unitDone = 1'b1;
    repeat (20) @(negedge clk);
    check_dispatches("ovf");

    // ---------------- timeout on a stalled KCH, queued HELLO follows
    unitDone = 1'b0;
    t0 = cyc + 1;
    send(3'd1, 16'd30, 16'd0, 8'd1, 1'b1);
    send(3'd0, 16'd31, 16'd0, 8'd1, 1'b1);
    w = t0 + 3;
    while (cyc < w + TO - 1) @(negedge clk);
    chk("to early", timeoutErr, 0);
    @(negedge clk);
    chk("to set", timeoutErr, 1);
    unitDone = 1'b1;
    repeat (6) @(negedge clk);
    if (obs_q.size() >= 2) chk("to next latency", obs_q[1].cyc, w + TO + 2);
    check_dispatches("to");

    // ---------------- reset during WAIT with two headers queued
    unitDone = 1'b0;
    send(3'd0, 16'd40, 16'd0, 8'd1, 1'b1);
    send(3'd0, 16'd41, 16'd0, 8'd1, 1'b1);
    send(3'd0, 16'd42, 16'd0, 8'd1, 1'b1);
    repeat (4) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    cache_q.delete();
    exp_drops = 0;
    exp_q.delete();
    obs_q.delete();
    unitDone = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst no enable", obs_q.size(), 0);
    send(3'd0, 16'd40, 16'd0, 8'd1, 1'b1);
    repeat (6) @(negedge clk);
    check_dispatches("postrst");
    chk("postrst dropCount", dropCount, exp_drops);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
